mfp_adc_max10_sequencer: RTL and testbench



---
 rtl/mfp_adc_max10_pkg.sv | 18 +
 rtl/mfp_adc_max10_priority_find.sv | 37 +++
 rtl/mfp_adc_max10_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_mfp_adc_max10_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_adc_max10_pkg.sv
// Shared definitions for the MAX10 ADC scan sequencer.
//   seq_state_t : scan FSM states
//   ADC_DATA_W  : width of one ADC conversion result
//   ADC_CH_W    : width of the ADC IP core channel field
package mfp_adc_max10_pkg;

  localparam int ADC_DATA_W = 12;
  localparam int ADC_CH_W   = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FIND = 3'd1,
    ST_CMD  = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } seq_state_t;

endpackage

// File: rtl/mfp_adc_max10_priority_find.sv
// Lowest-set-bit search at or above a starting index.
//   mask     : candidate bits (enabled channels)
//   from_idx : lowest index allowed; a value of NCH or more finds nothing
//   found    : a qualifying bit exists
//   idx      : index of the lowest qualifying bit (0 when not found)
module mfp_adc_max10_priority_find
  import mfp_adc_max10_pkg::*;
#(
  parameter int  NCH   = 8,
  localparam int IDX_W = $clog2(NCH + 1)
) (
  input  logic [NCH-1:0]   mask,
  input  logic [IDX_W-1:0] from_idx,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Bits below the starting index are masked off before the search.
  logic [NCH-1:0] qual;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_qual
    assign qual[gi] = mask[gi] && (from_idx <= IDX_W'(gi));
  end

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (qual[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mfp_adc_max10_sequencer.sv
// Scan sequencer between the system ADC peripheral and the MAX10 ADC IP core.
// Walks a latched channel mask one channel at a time, issuing one Avalon-ST
// command per channel and capturing the matching response into a per-channel
// result register file.
//   SI_ClkIn, SI_Reset      : clock, synchronous active-high reset
//   ctl_start/cont/mask/stop: software scan control
//   stat_busy/done/err      : scan status (done is a one-cycle pulse, err sticky)
//   smp_valid               : per-channel "result captured since last start"
//   rd_ch -> rd_data        : registered result read port (1 cycle latency)
//   ADC_C_*                 : command stream to the ADC core
//   ADC_R_*                 : response stream from the ADC core (no backpressure)
module mfp_adc_max10_sequencer
  import mfp_adc_max10_pkg::*;
#(
  parameter int  NCH     = 8,
  parameter int  TIMEOUT = 1024,
  localparam int RD_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  SI_ClkIn,
  input  logic                  SI_Reset,
  input  logic                  ctl_start,
  input  logic                  ctl_cont,
  input  logic [NCH-1:0]        ctl_mask,
  input  logic                  ctl_stop,
  output logic                  stat_busy,
  output logic                  stat_done,
  output logic                  stat_err,
  output logic [NCH-1:0]        smp_valid,
  input  logic [RD_W-1:0]       rd_ch,
  output logic [ADC_DATA_W-1:0] rd_data,
  output logic                  ADC_C_Valid,
  output logic [ADC_CH_W-1:0]   ADC_C_Channel,
  output logic                  ADC_C_SOP,
  output logic                  ADC_C_EOP,
  input  logic                  ADC_C_Ready,
  input  logic                  ADC_R_Valid,
  input  logic [ADC_CH_W-1:0]   ADC_R_Channel,
  input  logic [ADC_DATA_W-1:0] ADC_R_Data,
  input  logic                  ADC_R_SOP,
  input  logic                  ADC_R_EOP
);

  // ch_reg must be able to hold NCH (one past the last channel) so that
  // "next channel" after the last one falls through FIND to DONE.
  localparam int CH_W  = $clog2(NCH + 1);
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  seq_state_t            state_reg, state_next;
  logic [CH_W-1:0]       ch_reg, ch_next;
  logic [NCH-1:0]        mask_reg, mask_next;
  logic                  cont_reg, cont_next;
  logic                  stop_reg, stop_next;
  logic                  err_reg, err_next;
  logic [NCH-1:0]        smp_valid_reg, smp_valid_next;
  logic [TMO_W-1:0]      tmo_reg, tmo_next;
  // Set by the first accepted start after reset. Until then a stray response
  // seen in IDLE belongs to a conversion that reset abandoned and is not an error.
  logic                  armed_reg, armed_next;

  logic                  cap_en;
  logic [RD_W-1:0]       cap_idx;
  logic                  find_found;
  logic [CH_W-1:0]       find_idx;
  logic                  resp_match;

  logic [ADC_DATA_W-1:0] result_reg [NCH];
  logic [ADC_DATA_W-1:0] rd_data_reg;

  // Response framing is fixed at single-beat packets; SOP/EOP carry no information.
  logic unused_resp_framing;
  assign unused_resp_framing = ADC_R_SOP ^ ADC_R_EOP;

  mfp_adc_max10_priority_find #(
    .NCH (NCH)
  ) u_find (
    .mask     (mask_reg),
    .from_idx (ch_reg),
    .found    (find_found),
    .idx      (find_idx)
  );

  assign cap_idx    = RD_W'(ch_reg);
  assign resp_match = ADC_R_Valid && (ADC_R_Channel == ADC_CH_W'(ch_reg));

  // ---------------------------------------------------------------------------
  // State register and scan context
  // ---------------------------------------------------------------------------
  always_ff @(posedge SI_ClkIn) begin
    if (SI_Reset) begin
      state_reg     <= ST_IDLE;
      ch_reg        <= '0;
      mask_reg      <= '0;
      cont_reg      <= 1'b0;
      stop_reg      <= 1'b0;
      err_reg       <= 1'b0;
      smp_valid_reg <= '0;
      tmo_reg       <= '0;
      armed_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ch_reg        <= ch_next;
      mask_reg      <= mask_next;
      cont_reg      <= cont_next;
      stop_reg      <= stop_next;
      err_reg       <= err_next;
      smp_valid_reg <= smp_valid_next;
      tmo_reg       <= tmo_next;
      armed_reg     <= armed_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    ch_next        = ch_reg;
    mask_next      = mask_reg;
    cont_next      = cont_reg;
    stop_next      = stop_reg;
    err_next       = err_reg;
    smp_valid_next = smp_valid_reg;
    tmo_next       = tmo_reg;
    armed_next     = armed_reg;
    cap_en         = 1'b0;

    if ((state_reg != ST_IDLE) && ctl_stop) begin
      stop_next = 1'b1;
    end

    // Responses only make sense while waiting for one.
    if (ADC_R_Valid && (state_reg != ST_WAIT) &&
        ((state_reg != ST_IDLE) || armed_reg)) begin
      err_next = 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
        if (ctl_start) begin
          mask_next      = ctl_mask;
          err_next       = 1'b0;
          smp_valid_next = '0;
          cont_next      = ctl_cont;
          ch_next        = '0;
          armed_next     = 1'b1;
          state_next     = ST_FIND;
        end
      end

      ST_FIND: begin
        if (find_found) begin
          ch_next    = find_idx;
          state_next = ST_CMD;
        end else begin
          state_next = ST_DONE;
        end
      end

      ST_CMD: begin
        if (ADC_C_Ready) begin
          tmo_next   = '0;
          state_next = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (resp_match) begin
          cap_en                  = 1'b1;
          smp_valid_next[cap_idx] = 1'b1;
          ch_next                 = ch_reg + CH_W'(1);
          state_next              = ST_FIND;
        end else begin
          if (ADC_R_Valid) begin
            err_next = 1'b1;
          end
          if (tmo_reg == TMO_LAST) begin
            err_next   = 1'b1;
            ch_next    = ch_reg + CH_W'(1);
            state_next = ST_FIND;
          end else begin
            tmo_next = tmo_reg + TMO_W'(1);
          end
        end
      end

      ST_DONE: begin
        // A stop arriving in this very cycle also ends continuous mode.
        if (cont_reg && !stop_reg && !ctl_stop) begin
          ch_next    = '0;
          state_next = ST_FIND;
        end else begin
          stop_next  = 1'b0;
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result register file and registered read port. The read samples the
  // array before this edge's capture, so a same-cycle capture shows up one
  // cycle later.
  // ---------------------------------------------------------------------------
  always_ff @(posedge SI_ClkIn) begin
    if (SI_Reset) begin
      for (int i = 0; i < NCH; i++) begin
        result_reg[i] <= '0;
      end
      rd_data_reg <= '0;
    end else begin
      if (cap_en) begin
        result_reg[cap_idx] <= ADC_R_Data;
      end
      if (32'(rd_ch) < NCH) begin
        rd_data_reg <= result_reg[rd_ch];
      end else begin
        rd_data_reg <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from registered state so reset clears them at the edge.
  // ---------------------------------------------------------------------------
  assign ADC_C_Valid   = (state_reg == ST_CMD);
  assign ADC_C_Channel = (state_reg == ST_CMD) ? ADC_CH_W'(ch_reg) : '0;
  assign ADC_C_SOP     = (state_reg == ST_CMD);
  assign ADC_C_EOP     = (state_reg == ST_CMD);

  assign stat_busy = (state_reg != ST_IDLE);
  assign stat_done = (state_reg == ST_DONE);
  assign stat_err  = err_reg;
  assign smp_valid = smp_valid_reg;
  assign rd_data   = rd_data_reg;

endmodule

// File: tb/tb_mfp_adc_max10_sequencer.sv
// Directed bench for mfp_adc_max10_sequencer with a command scoreboard and an
// ADC response model. Inputs change and outputs are sampled on the falling edge.
module tb_mfp_adc_max10_sequencer;

  localparam int NCH     = 8;
  localparam int TIMEOUT = 16;
  localparam int LAT     = 5;

  logic        clk;
  logic        srst;
  logic        ctl_start, ctl_cont, ctl_stop;
  logic [7:0]  ctl_mask;
  logic        stat_busy, stat_done, stat_err;
  logic [7:0]  smp_valid;
  logic [2:0]  rd_ch;
  logic [11:0] rd_data;
  logic        c_valid, c_sop, c_eop, c_ready;
  logic [4:0]  c_channel;
  logic        r_valid, r_sop, r_eop;
  logic [4:0]  r_channel;
  logic [11:0] r_data;

  mfp_adc_max10_sequencer #(.NCH(NCH), .TIMEOUT(TIMEOUT)) dut (
    .SI_ClkIn      (clk),
    .SI_Reset      (srst),
    .ctl_start     (ctl_start),
    .ctl_cont      (ctl_cont),
    .ctl_mask      (ctl_mask),
    .ctl_stop      (ctl_stop),
    .stat_busy     (stat_busy),
    .stat_done     (stat_done),
    .stat_err      (stat_err),
    .smp_valid     (smp_valid),
    .rd_ch         (rd_ch),
    .rd_data       (rd_data),
    .ADC_C_Valid   (c_valid),
    .ADC_C_Channel (c_channel),
    .ADC_C_SOP     (c_sop),
    .ADC_C_EOP     (c_eop),
    .ADC_C_Ready   (c_ready),
    .ADC_R_Valid   (r_valid),
    .ADC_R_Channel (r_channel),
    .ADC_R_Data    (r_data),
    .ADC_R_SOP     (r_sop),
    .ADC_R_EOP     (r_eop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ch;
    int          due;
    logic [11:0] data;
  } resp_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          ncyc = 0;
  int          done_cnt = 0;
  int          valid_cycles = 0;
  int          acc_count = 0;
  int          last_acc = 0;
  int          acc_hist[$];
  logic [4:0]  exp_cmd_q[$];
  resp_t       resp_q[$];
  logic        drop_en = 1'b0;
  logic [4:0]  drop_ch = 5'd0;
  logic        inject_wrong = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // ADC model and command scoreboard. Runs 1 ns after the falling edge so it
  // sees the inputs the stimulus just drove; acts on what the next rising
  // edge will sample.
  initial begin
    r_valid = 1'b0; r_channel = '0; r_data = '0; r_sop = 1'b0; r_eop = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      ncyc++;
      r_valid = 1'b0; r_sop = 1'b0; r_eop = 1'b0;
      if (resp_q.size() > 0 && resp_q[0].due <= ncyc) begin
        resp_t r;
        r = resp_q.pop_front();
        r_valid = 1'b1; r_channel = r.ch; r_data = r.data; r_sop = 1'b1; r_eop = 1'b1;
      end
      if (stat_done) done_cnt++;
      if (c_valid) valid_cycles++;
      if (c_valid && c_ready) begin
        $display("[%0d] cmd accepted ch=%0d", ncyc, c_channel);
        if (exp_cmd_q.size() == 0) chk("cmd_unexpected", 32'(c_channel), 32'h1F);
        else chk("cmd_ch", 32'(c_channel), 32'(exp_cmd_q.pop_front()));
        chk("cmd_sop_eop", {30'd0, c_sop, c_eop}, 32'h3);
        acc_count++;
        last_acc = ncyc;
        acc_hist.push_back(ncyc);
        if (inject_wrong)
          resp_q.push_back('{ch: 5'd2, due: ncyc + 3, data: 12'h222});
        if (!(drop_en && c_channel == drop_ch))
          resp_q.push_back('{ch: c_channel, due: ncyc + LAT, data: 12'hA00 + 12'(c_channel)});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Start pulse; mask is removed right after to confirm it was latched.
  task automatic start_scan(input logic [7:0] mask, input logic cont);
    for (int i = 0; i < NCH; i++)
      if (mask[i]) exp_cmd_q.push_back(5'(i));
    ctl_mask = mask; ctl_cont = cont; ctl_start = 1'b1;
    @(negedge clk);
    ctl_start = 1'b0; ctl_mask = '0; ctl_cont = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (stat_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_budget", 32'(stat_busy), 32'h0);
  endtask

  task automatic read_chk(input string tag, input logic [2:0] ch, input logic [11:0] exp_v);
    rd_ch = ch;
    @(negedge clk);
    chk(tag, 32'(rd_data), 32'(exp_v));
  endtask

  initial begin
    int d0, a0, n;
    srst = 1'b1; ctl_start = 1'b0; ctl_cont = 1'b0; ctl_stop = 1'b0;
    ctl_mask = '0; rd_ch = '0; c_ready = 1'b1;
    tick(3);

    // Reset state
    chk("rst_busy", 32'(stat_busy), 0);
    chk("rst_done", 32'(stat_done), 0);
    chk("rst_err", 32'(stat_err), 0);
    chk("rst_smp_valid", 32'(smp_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_cmd", {c_valid, c_channel, c_sop, c_eop}, 0);
    srst = 1'b0;
    tick(2);

    // Mask A1, single scan: commands 0,5,7 in order
    d0 = done_cnt;
    start_scan(8'hA1, 1'b0);
    chk("lat_find_busy", 32'(stat_busy), 1);
    chk("lat_find_novalid", 32'(c_valid), 0);
    @(negedge clk);
    chk("lat_cmd_valid", 32'(c_valid), 1);
    chk("lat_cmd_ch0", 32'(c_channel), 0);
    wait_idle(200);
    chk("a1_done_pulses", 32'(done_cnt - d0), 1);
    chk("a1_smp_valid", 32'(smp_valid), 32'hA1);
    chk("a1_err", 32'(stat_err), 0);
    chk("a1_cmds_left", 32'(exp_cmd_q.size()), 0);
    read_chk("a1_rd5", 3'd5, 12'hA05);
    read_chk("a1_rd7", 3'd7, 12'hA07);
    read_chk("a1_rd1", 3'd1, 12'h000);

    // Empty mask: FIND then DONE, no command
    a0 = valid_cycles;
    start_scan(8'h00, 1'b0);
    chk("m0_find_nodone", 32'(stat_done), 0);
    @(negedge clk);
    chk("m0_done_n2", 32'(stat_done), 1);
    @(negedge clk);
    chk("m0_idle", 32'(stat_busy), 0);
    chk("m0_no_valid", 32'(valid_cycles - a0), 0);
    chk("m0_err", 32'(stat_err), 0);

    // Ready low for 20 cycles on channel 3
    c_ready = 1'b0;
    start_scan(8'h08, 1'b0);
    n = 0;
    while (!c_valid && n < 10) begin @(negedge clk); n++; end
    chk("rdy_valid_seen", 32'(c_valid), 1);
    for (int i = 0; i < 20; i++) begin
      chk("rdy_hold_valid", 32'(c_valid), 1);
      chk("rdy_hold_ch", 32'(c_channel), 3);
      @(negedge clk);
    end
    c_ready = 1'b1;
    a0 = ncyc + 1;
    @(negedge clk);
    chk("rdy_accept_cycle", 32'(last_acc), 32'(a0));
    chk("rdy_valid_drop", 32'(c_valid), 0);
    wait_idle(200);
    chk("rdy_smp", 32'(smp_valid), 32'h08);

    // Wrong-channel response while channel 4 outstanding
    inject_wrong = 1'b1;
    start_scan(8'h10, 1'b0);
    tick(2);
    inject_wrong = 1'b0;
    wait_idle(200);
    chk("mis_err", 32'(stat_err), 1);
    chk("mis_smp", 32'(smp_valid), 32'h10);
    read_chk("mis_rd2_unchanged", 3'd2, 12'h000);
    read_chk("mis_rd4", 3'd4, 12'hA04);

    // Timeout on channel 1, mask 06
    drop_en = 1'b1; drop_ch = 5'd1;
    acc_hist.delete();
    start_scan(8'h06, 1'b0);
    chk("tmo_err_cleared", 32'(stat_err), 0);
    wait_idle(300);
    drop_en = 1'b0;
    chk("tmo_err", 32'(stat_err), 1);
    chk("tmo_smp", 32'(smp_valid), 32'h04);
    chk("tmo_cmds", 32'(acc_hist.size()), 2);
    // 16 WAIT cycles, one FIND, then the CMD cycle whose edge accepts channel 2.
    if (acc_hist.size() == 2)
      chk("tmo_gap", 32'(acc_hist[1] - acc_hist[0]), 32'(TIMEOUT + 2));

    // Continuous mode, stop during second scan
    d0 = done_cnt;
    start_scan(8'h03, 1'b1);
    exp_cmd_q.push_back(5'd0); exp_cmd_q.push_back(5'd1);
    n = 0;
    while (done_cnt == d0 && n < 200) begin @(negedge clk); n++; end
    chk("cont_first_done", 32'(done_cnt - d0), 1);
    tick(3);
    ctl_stop = 1'b1;
    tick(1);
    ctl_stop = 1'b0;
    wait_idle(200);
    tick(5);
    chk("cont_two_dones", 32'(done_cnt - d0), 2);
    chk("cont_idle", 32'(stat_busy), 0);
    chk("cont_cmds_left", 32'(exp_cmd_q.size()), 0);
    chk("cont_smp", 32'(smp_valid), 32'h03);

    // Reset during the third run of a continuous scan
    d0 = done_cnt;
    rd_ch = 3'd0;
    start_scan(8'h03, 1'b1);
    for (int i = 0; i < 2; i++) begin
      exp_cmd_q.push_back(5'd0); exp_cmd_q.push_back(5'd1);
    end
    n = 0;
    while (done_cnt - d0 < 2 && n < 300) begin @(negedge clk); n++; end
    chk("rst3_two_dones", 32'(done_cnt - d0), 2);
    a0 = acc_count;
    n = 0;
    while (acc_count == a0 && n < 50) begin @(negedge clk); n++; end
    chk("rst3_cmd_outstanding", 32'(acc_count - a0), 1);
    chk("rst3_pre_busy", 32'(stat_busy), 1);
    chk("rst3_pre_rd", 32'(rd_data), 32'hA00);
    srst = 1'b1;
    @(negedge clk);
    chk("rst3_busy", 32'(stat_busy), 0);
    chk("rst3_done", 32'(stat_done), 0);
    chk("rst3_err", 32'(stat_err), 0);
    chk("rst3_smp", 32'(smp_valid), 0);
    chk("rst3_rd", 32'(rd_data), 0);
    chk("rst3_cmd", {c_valid, c_channel, c_sop, c_eop}, 0);
    srst = 1'b0;
    exp_cmd_q.delete();
    tick(8);
    chk("late_resp_no_err", 32'(stat_err), 0);
    chk("late_resp_idle", 32'(stat_busy), 0);
    chk("late_resp_rd", 32'(rd_data), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
